// File: rtl/uart_pkg.sv
// Shared UART constants and the 2-bit FSM encodings used by the TX feeder and the
// RX-side blocks.
package uart_pkg;

  localparam int CLK_FREQ     = 50_000_000;
  localparam int BAUD         = 115200;
  localparam int CLKS_PER_BIT = 434;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_ACK  = 2'd2,
    ST_WAIT_DONE = 2'd3
  } fsm_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with fall-through head, occupancy count and a write-while-full
// strobe that the parent turns into a sticky flag.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_head,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_ovf
);

  localparam int                 PTR_W    = $clog2(DEPTH);
  localparam logic [PTR_W-1:0]   PTR_ONE  = 1;
  localparam logic [PTR_W:0]     LVL_ONE  = 1;
  localparam logic [PTR_W:0]     LVL_FULL = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_level;
  logic             w_push_ok;
  logic             w_pop_ok;

  // full is the registered occupancy, so a pop in the same clk does not make room
  assign o_full    = (r_level == LVL_FULL);
  assign o_empty   = (r_level == '0);
  assign o_level   = r_level;
  assign o_head    = r_mem[r_rd_ptr];
  assign o_ovf     = i_push && o_full;
  assign w_push_ok = i_push && !o_full;
  assign w_pop_ok  = i_pop && !o_empty;

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + PTR_ONE;
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + PTR_ONE;
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LVL_ONE;
        2'b01:   r_level <= r_level - LVL_ONE;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte queue and launch FSM feeding uart_top's transmitter: one byte per frame,
// paced by the UART busy flag, with an ack timeout for a transmitter that never responds.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int ACK_TIMEOUT = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  output logic                   tx_err,
  input  logic                   clr_flags,
  output logic [7:0]             tx_data,
  output logic                   tx_send,
  input  logic                   tx_busy,
  output logic                   idle
);

  localparam int               CNT_W    = $clog2(ACK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

  fsm_state_t        r_state;
  logic [CNT_W-1:0]  r_ack_cnt;
  logic [7:0]        r_tx_data;
  logic              r_tx_send;
  logic              r_overflow;
  logic              r_tx_err;

  logic              w_pop;
  logic              w_ovf;
  logic              w_timeout;
  logic              w_empty;
  logic              w_full;
  logic [7:0]        w_head;
  logic [$clog2(DEPTH):0] w_level;

  // The !tx_busy guard also holds off launches after a reset that interrupted a frame
  assign w_pop     = (r_state == ST_IDLE) && !w_empty && !tx_busy;
  assign w_timeout = (r_state == ST_WAIT_ACK) && !tx_busy && (r_ack_cnt == CNT_LAST);

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (wr_en),
    .i_wdata (wr_data),
    .i_pop   (w_pop),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level),
    .o_ovf   (w_ovf)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_ack_cnt <= '0;
      r_tx_data <= '0;
      r_tx_send <= 1'b0;
    end else begin
      r_tx_send <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pop) begin
            r_tx_data <= w_head;
            r_tx_send <= 1'b1;
            r_state   <= ST_LAUNCH;
          end
        end
        ST_LAUNCH: begin
          // The LAUNCH clk itself counts as the first elapsed clk of the ack window
          r_ack_cnt <= CNT_ONE;
          r_state   <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (tx_busy) begin
            r_state <= ST_WAIT_DONE;
          end else if (w_timeout) begin
            r_state <= ST_IDLE;
          end else begin
            r_ack_cnt <= r_ack_cnt + CNT_ONE;
          end
        end
        ST_WAIT_DONE: begin
          if (!tx_busy) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
      r_tx_err   <= 1'b0;
    end else begin
      if (clr_flags)  r_overflow <= 1'b0;
      else if (w_ovf) r_overflow <= 1'b1;
      if (clr_flags)      r_tx_err <= 1'b0;
      else if (w_timeout) r_tx_err <= 1'b1;
    end
  end

  assign full     = w_full;
  assign empty    = w_empty;
  assign level    = w_level;
  assign overflow = r_overflow;
  assign tx_err   = r_tx_err;
  assign tx_data  = r_tx_data;
  assign tx_send  = r_tx_send;
  assign idle     = w_empty && (r_state == ST_IDLE);

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Scoreboard bench for uart_tx_feeder with a behavioural stand-in for uart_top's
// busy handshake (short frames, optional forced busy, optional missing ack).
`timescale 1ns/1ps
module tb_uart_tx_feeder;

  localparam int BIT_CLKS   = 4;
  localparam int FRAME_CLKS = 10 * BIT_CLKS;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       clr_flags = 1'b0;
  logic       full, empty, overflow, tx_err, tx_send, tx_busy, idle;
  logic [4:0] level;
  logic [7:0] tx_data;

  logic       m_busy = 1'b0;
  int         m_cnt = 0;
  logic       ack_en = 1'b1;
  logic       force_busy = 1'b0;

  logic [7:0] exp_q[$];
  int         n_vec = 0;
  int         n_bad = 0;

  uart_tx_feeder #(.DEPTH(16), .ACK_TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .overflow(overflow),
    .tx_err(tx_err), .clr_flags(clr_flags), .tx_data(tx_data),
    .tx_send(tx_send), .tx_busy(tx_busy), .idle(idle)
  );

  always #5 clk = ~clk;

  assign tx_busy = m_busy | force_busy;

  // uart_top stand-in: busy rises the clk after send and lasts one short frame
  always @(posedge clk) begin
    if (!m_busy) begin
      if (tx_send && ack_en) begin
        m_busy <= 1'b1;
        m_cnt  <= FRAME_CLKS - 1;
      end
    end else if (m_cnt == 0) begin
      m_busy <= 1'b0;
    end else begin
      m_cnt <= m_cnt - 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every launch
  logic       prev_send = 1'b0;
  logic       prev_busy = 1'b0;
  logic       last_vld = 1'b0;
  logic [7:0] last_data = 8'h00;
  always @(negedge clk) begin
    if (rst) last_vld = 1'b0;
    if (tx_send) begin
      if (prev_send) begin
        n_vec++; n_bad++;
        $display("FAIL send_back_to_back: got tx_send high two clks, required single pulse");
      end
      if (exp_q.size() == 0) begin
        n_vec++; n_bad++;
        $display("FAIL unexpected_launch: got byte %02h, required no launch", tx_data);
      end else begin
        chk("launch_data", {24'd0, tx_data}, {24'd0, exp_q.pop_front()});
      end
      last_data = tx_data;
      last_vld  = 1'b1;
    end
    if (prev_busy && !tx_busy && last_vld)
      chk("data_held_through_frame", {24'd0, tx_data}, {24'd0, last_data});
    prev_send = tx_send;
    prev_busy = tx_busy;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [7:0] b);
    wr_en   = 1'b1;
    wr_data = b;
    tick();
    wr_en   = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n = 0;
    while (!(idle && !tx_busy) && n < budget) begin
      tick();
      n++;
    end
    chk(name, {31'd0, idle && !tx_busy}, 32'd1);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: got no finish, required finish within 500us");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic early;

    tick(); tick();
    rst = 1'b0;
    chk("rst_full", {31'd0, full}, 32'd0);
    chk("rst_empty", {31'd0, empty}, 32'd1);
    chk("rst_level", {27'd0, level}, 32'd0);
    chk("rst_overflow", {31'd0, overflow}, 32'd0);
    chk("rst_tx_err", {31'd0, tx_err}, 32'd0);
    chk("rst_tx_data", {24'd0, tx_data}, 32'h00);
    chk("rst_tx_send", {31'd0, tx_send}, 32'd0);
    chk("rst_idle", {31'd0, idle}, 32'd1);

    // 1: single byte, launch two clks after the write
    exp_q.push_back(8'hA5);
    wr(8'hA5);
    chk("single_level_1", {27'd0, level}, 32'd1);
    chk("single_no_send_yet", {31'd0, tx_send}, 32'd0);
    tick();
    chk("single_send_n2", {31'd0, tx_send}, 32'd1);
    chk("single_level_0", {27'd0, level}, 32'd0);
    wait_idle("single_idle", 200);

    // 2: burst of 16, first byte already popped when the 16th lands
    for (int i = 1; i <= 16; i++) begin
      exp_q.push_back(8'(i));
      wr(8'(i));
    end
    chk("burst_level_15", {27'd0, level}, 32'd15);
    chk("burst_not_full", {31'd0, full}, 32'd0);
    n = 0;
    while (tx_busy && n < 100) begin tick(); n++; end
    chk("burst_busy_fell", {31'd0, tx_busy}, 32'd0);
    chk("relaunch_gap_0", {31'd0, tx_send}, 32'd0);
    tick();
    chk("relaunch_gap_1", {31'd0, tx_send}, 32'd0);
    tick();
    chk("relaunch_gap_2", {31'd0, tx_send}, 32'd1);
    wait_idle("burst_idle", 2000);

    // 3: fill to 16 while held busy, then overflow and flag clear
    force_busy = 1'b1;
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back(8'h20 + 8'(i));
      wr(8'h20 + 8'(i));
    end
    chk("fill_full", {31'd0, full}, 32'd1);
    chk("fill_level_16", {27'd0, level}, 32'd16);
    wr(8'hFF);
    chk("ovf_set", {31'd0, overflow}, 32'd1);
    chk("ovf_level_16", {27'd0, level}, 32'd16);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("ovf_cleared", {31'd0, overflow}, 32'd0);
    clr_flags = 1'b1;
    wr(8'hFF);
    clr_flags = 1'b0;
    chk("clr_beats_set", {31'd0, overflow}, 32'd0);
    force_busy = 1'b0;
    wait_idle("fill_idle", 2000);

    // 4: transmitter never acks
    ack_en = 1'b0;
    exp_q.push_back(8'h51);
    exp_q.push_back(8'h52);
    wr(8'h51);
    wr(8'h52);
    chk("to_send", {31'd0, tx_send}, 32'd1);
    repeat (7) tick();
    chk("to_err_not_yet", {31'd0, tx_err}, 32'd0);
    tick();
    chk("to_err_at_8", {31'd0, tx_err}, 32'd1);
    tick();
    chk("to_relaunch", {31'd0, tx_send}, 32'd1);
    wait_idle("to_idle", 50);
    clr_flags = 1'b1;
    tick();
    clr_flags = 1'b0;
    chk("to_err_cleared", {31'd0, tx_err}, 32'd0);
    ack_en = 1'b1;

    // 5: reset in the middle of frame 3C with 5 bytes queued
    force_busy = 1'b1;
    exp_q.push_back(8'h3C);
    wr(8'h3C);
    for (int i = 1; i <= 5; i++) wr(8'h60 + 8'(i));
    force_busy = 1'b0;
    n = 0;
    while (!tx_send && n < 20) begin tick(); n++; end
    chk("mid_launch_3c", {31'd0, tx_send}, 32'd1);
    repeat (1 + 4 * BIT_CLKS) tick();
    chk("mid_frame_busy", {31'd0, tx_busy}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_level", {27'd0, level}, 32'd0);
    chk("mid_rst_empty", {31'd0, empty}, 32'd1);
    chk("mid_rst_tx_data", {24'd0, tx_data}, 32'h00);
    exp_q.push_back(8'h77);
    wr(8'h77);
    early = 1'b0;
    n = 0;
    while (tx_busy && n < 100) begin
      if (tx_send) early = 1'b1;
      tick();
      n++;
    end
    chk("mid_no_launch_while_busy", {31'd0, early}, 32'd0);
    wait_idle("mid_idle", 200);

    // 6: push and pop in the same clk at level 1
    force_busy = 1'b1;
    exp_q.push_back(8'h81);
    wr(8'h81);
    chk("sim_level_1", {27'd0, level}, 32'd1);
    force_busy = 1'b0;
    exp_q.push_back(8'h82);
    wr(8'h82);
    chk("sim_level_still_1", {27'd0, level}, 32'd1);
    chk("sim_send", {31'd0, tx_send}, 32'd1);
    wait_idle("sim_idle", 300);

    tick();
    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
